p2s_arbiter: RTL and testbench
==============================

P2S_ARBITER -- requirements
Module: p2s_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 12, SHALL set the width of each element.
REQ-002 Parameter NUM_ELEMENTS, default 5, SHALL set the number of elements per parallel vector.
REQ-003 Parameter NUM_REQ, default 4, SHALL set the number of requesters (2 or more).
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-low reset.
REQ-006 arb_valid_in  input  NUM_REQ  SHALL carry the per-requester vector-valid bits.
REQ-007 arb_ready_in  output  NUM_REQ  SHALL carry the per-requester accept bits.
REQ-008 arb_parallel_in  input  NUM_REQ x NUM_ELEMENTS x DATA_WIDTH  SHALL carry the per-requester vectors.
REQ-009 arb_ready_out  input  1  SHALL carry downstream ready.
REQ-010 arb_valid_out  output  1  SHALL mark the serial element as valid.
REQ-011 arb_serial_out  output  DATA_WIDTH  SHALL carry the current element.
REQ-012 arb_last_out  output  1  SHALL mark the final element of a vector.
REQ-013 arb_id_out  output  clog2(NUM_REQ)  SHALL carry the index of the requester that owns the current vector.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and SEND.
REQ-015 In IDLE with no arb_valid_in bit set, all arb_ready_in bits SHALL be 0 and the state SHALL remain IDLE.
REQ-016 In IDLE with any arb_valid_in bit set, exactly one arb_ready_in bit SHALL be driven high, combinationally, for the granted index g.
REQ-017 Round-robin selection: g SHALL be the first set valid bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
REQ-018 On the grant cycle, the block SHALL capture arb_parallel_in[g] into the vector buffer, register g as owner, set last_grant to g, clear count to 0 and enter SEND.
REQ-019 In SEND, arb_ready_in SHALL be all 0.
REQ-020 In SEND, arb_valid_out SHALL be 1, arb_serial_out SHALL equal buffer[count], arb_id_out SHALL equal owner, and arb_last_out SHALL equal (count == NUM_ELEMENTS-1).
REQ-021 A transfer SHALL occur on a cycle with arb_valid_out and arb_ready_out both high; each transfer SHALL increment count.
REQ-022 Without a transfer, all outputs SHALL hold stable.
REQ-023 A transfer with arb_last_out high SHALL return the FSM to IDLE.
REQ-024 Outside SEND, arb_valid_out and arb_last_out SHALL be 0.
REQ-025 Latency: the first element SHALL appear the cycle after the grant.
REQ-026 A vector SHALL take NUM_ELEMENTS transfer cycles plus one IDLE cycle.
REQ-027 arb_valid_in bits that change while the FSM is in SEND SHALL have no effect.
REQ-028 The counter SHALL be clog2(NUM_ELEMENTS) bits wide and SHALL never exceed NUM_ELEMENTS-1.

Reset
REQ-029 While rst=0 at a clock edge, the block SHALL set: state IDLE, count 0, owner 0, last_grant NUM_REQ-1 (so requester 0 wins first), arb_valid_out 0, arb_last_out 0, arb_ready_in all 0, arb_id_out 0 and arb_serial_out 0.
REQ-030 A reset asserted mid-vector SHALL discard the remaining elements; no further element of that vector SHALL be output.

Configuration
REQ-031 With macro P2S_ARB_FIXED_PRIO_EN defined, g SHALL be the lowest-index set valid bit, and last_grant SHALL be unused.
REQ-032 Without P2S_ARB_FIXED_PRIO_EN, round-robin selection per REQ-017 SHALL apply.

Verification (NUM_REQ=4, NUM_ELEMENTS=5, DATA_WIDTH=12)
REQ-033 Single requester: req 2 sends {1,2,3,4,5} with ready_out held 1 -> outputs 1..5 on consecutive cycles, id=2, last high only on 5, then one idle cycle.
REQ-034 All four requesters valid continuously -> grant order 0,1,2,3,0 (round-robin); with P2S_ARB_FIXED_PRIO_EN -> grant order 0,0,0.
REQ-035 Backpressure: ready_out=0 for 3 cycles during element 3 -> element 3 held stable for all 3 cycles, with no loss or duplication.
REQ-036 Reset asserted after element 2 of req 1 -> the next cycle shows valid_out=0 and ready_in=0; after release, req 0 is granted first.
REQ-037 Req 3 drops valid and req 0 raises valid during SEND -> the current vector completes unchanged; req 0 is granted in the following IDLE.

Source files
------------

// File: rtl/p2s_arbiter.sv
// p2s_arbiter: arbitrates between NUM_REQ requesters, each offering a parallel vector of
// NUM_ELEMENTS elements of DATA_WIDTH bits. The granted vector is then serialised one element
// per transfer, with a valid/ready handshake on the serial side.
//
// Build option: define P2S_ARB_FIXED_PRIO_EN to use fixed priority, where the lowest index
// wins. Leave it undefined (the default) for round-robin.
//
// Ports:
//   clk             - clock; all state updates on the rising edge
//   rst             - synchronous reset, active low
//   arb_valid_in    - per-requester vector-valid bits
//   arb_ready_in    - per-requester accept bits (one-hot grant, combinational, in IDLE only)
//   arb_parallel_in - per-requester vectors, indexed [req][element]; element 0 is sent first
//   arb_ready_out   - downstream ready
//   arb_valid_out   - serial element valid
//   arb_serial_out  - current serial element
//   arb_last_out    - final element of the vector
//   arb_id_out      - index of the requester that owns the current vector
module p2s_arbiter #(
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned NUM_ELEMENTS = 5,
  parameter int unsigned NUM_REQ      = 4
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic [NUM_REQ-1:0]                                     arb_valid_in,
  output logic [NUM_REQ-1:0]                                     arb_ready_in,
  input  logic [NUM_REQ-1:0][NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]   arb_parallel_in,
  input  logic                                                   arb_ready_out,
  output logic                                                   arb_valid_out,
  output logic [DATA_WIDTH-1:0]                                  arb_serial_out,
  output logic                                                   arb_last_out,
  output logic [$clog2(NUM_REQ)-1:0]                             arb_id_out
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_ELEMENTS - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                                   state_q;
  logic [CntW-1:0]                          count_q;
  logic [CntW-1:0]                          count_next;
  logic [IdW-1:0]                           owner_q;
  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]  buffer_q;
  logic                                     grant_any;
  logic [IdW-1:0]                           grant_idx;
  logic                                     xfer;
`ifndef P2S_ARB_FIXED_PRIO_EN
  logic [IdW-1:0]                           last_grant_q;
  int unsigned                              cand;
`endif

  assign count_next = count_q + CntW'(1);
  assign xfer       = arb_valid_out & arb_ready_out;
  assign arb_id_out = owner_q;

  // Grant selection. The loops run from the least to the most preferred candidate, so the
  // final assignment is the winner.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
`ifdef P2S_ARB_FIXED_PRIO_EN
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (arb_valid_in[IdW'(i)]) begin
        grant_any = 1'b1;
        grant_idx = IdW'(i);
      end
    end
`else
    cand = 0;
    for (int unsigned i = NUM_REQ; i >= 1; i--) begin
      cand = (32'(last_grant_q) + i) % NUM_REQ;
      if (arb_valid_in[IdW'(cand)]) begin
        grant_any = 1'b1;
        grant_idx = IdW'(cand);
      end
    end
`endif
  end

  // Accept is offered only in IDLE. It is also gated by reset, so nothing is accepted while
  // reset is held.
  always_comb begin
    arb_ready_in = '0;
    if (rst && (state_q == StIdle) && grant_any) begin
      arb_ready_in[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StIdle;
      count_q        <= '0;
      owner_q        <= '0;
      buffer_q       <= '0;
      arb_valid_out  <= 1'b0;
      arb_last_out   <= 1'b0;
      arb_serial_out <= '0;
`ifndef P2S_ARB_FIXED_PRIO_EN
      last_grant_q   <= IdW'(NUM_REQ - 1);
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            buffer_q       <= arb_parallel_in[grant_idx];
            owner_q        <= grant_idx;
            count_q        <= '0;
            arb_valid_out  <= 1'b1;
            arb_serial_out <= arb_parallel_in[grant_idx][0];
            arb_last_out   <= (NUM_ELEMENTS == 1);
            state_q        <= StSend;
`ifndef P2S_ARB_FIXED_PRIO_EN
            last_grant_q   <= grant_idx;
`endif
          end
        end
        StSend: begin
          if (xfer) begin
            if (arb_last_out) begin
              arb_valid_out <= 1'b0;
              arb_last_out  <= 1'b0;
              state_q       <= StIdle;
            end else begin
              // Only reached while count < NUM_ELEMENTS-1, so count_next stays in range.
              count_q        <= count_next;
              arb_serial_out <= buffer_q[count_next];
              arb_last_out   <= (count_next == LastCnt);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_arbiter.sv
// Directed testbench for p2s_arbiter (NUM_REQ=4, NUM_ELEMENTS=5, DATA_WIDTH=12).
// Requester 2 carries {1,2,3,4,5}. Every other requester r carries element e as (r<<8)|(e+1).
module tb_p2s_arbiter;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [3:0]                  arb_valid_in;
  logic [3:0]                  arb_ready_in;
  logic [3:0][4:0][11:0]       arb_parallel_in;
  logic                        arb_ready_out;
  logic                        arb_valid_out;
  logic [11:0]                 arb_serial_out;
  logic                        arb_last_out;
  logic [1:0]                  arb_id_out;

  int checks = 0;
  int errors = 0;
  int exp_order [5];

  p2s_arbiter #(
    .DATA_WIDTH  (12),
    .NUM_ELEMENTS(5),
    .NUM_REQ     (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .arb_valid_in   (arb_valid_in),
    .arb_ready_in   (arb_ready_in),
    .arb_parallel_in(arb_parallel_in),
    .arb_ready_out  (arb_ready_out),
    .arb_valid_out  (arb_valid_out),
    .arb_serial_out (arb_serial_out),
    .arb_last_out   (arb_last_out),
    .arb_id_out     (arb_id_out)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] exp_data(input int r, input int e);
    if (r == 2) return 12'(e + 1);
    return 12'((r << 8) | (e + 1));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef P2S_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    for (int r = 0; r < 4; r++)
      for (int e = 0; e < 5; e++) arb_parallel_in[r][e] = exp_data(r, e);
    rst = 1'b0;
    arb_valid_in = 4'b0000;
    arb_ready_out = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_valid", arb_valid_out, 0);
    chk("rst_last", arb_last_out, 0);
    chk("rst_id", arb_id_out, 0);
    chk("rst_serial", arb_serial_out, 0);
    chk("rst_ready_in", arb_ready_in, 0);
    rst = 1'b1;
    step();
    chk("idle_no_req_ready", arb_ready_in, 0);
    chk("idle_no_req_valid", arb_valid_out, 0);

    // Single requester 2 sends 1..5 back to back, then one idle cycle
    arb_valid_in = 4'b0100;
    #1;
    chk("t1_grant", arb_ready_in, 4'b0100);
    step();
    arb_valid_in = 4'b0000;
    for (int e = 0; e < 5; e++) begin
      chk("t1_valid", arb_valid_out, 1);
      chk("t1_serial", arb_serial_out, e + 1);
      chk("t1_id", arb_id_out, 2);
      chk("t1_last", arb_last_out, (e == 4) ? 1 : 0);
      chk("t1_ready_in_send", arb_ready_in, 0);
      step();
    end
    chk("t1_idle_valid", arb_valid_out, 0);
    chk("t1_idle_last", arb_last_out, 0);

    // All four requesters valid continuously, starting from reset
    rst = 1'b0;
    step();
    rst = 1'b1;
    arb_valid_in = 4'b1111;
    #1;
    for (int v = 0; v < 5; v++) begin
      chk("t2_idle_valid", arb_valid_out, 0);
      chk("t2_grant", arb_ready_in, 32'(1) << exp_order[v]);
      step();
      for (int e = 0; e < 5; e++) begin
        chk("t2_id", arb_id_out, exp_order[v]);
        chk("t2_serial", arb_serial_out, exp_data(exp_order[v], e));
        chk("t2_last", arb_last_out, (e == 4) ? 1 : 0);
        step();
      end
    end
    arb_valid_in = 4'b0000;

    // Backpressure on the third element of requester 1
    arb_valid_in = 4'b0010;
    #1;
    chk("t3_grant", arb_ready_in, 4'b0010);
    step();
    arb_valid_in = 4'b0000;
    chk("t3_e0", arb_serial_out, 12'h101);
    step();
    chk("t3_e1", arb_serial_out, 12'h102);
    step();
    chk("t3_e2", arb_serial_out, 12'h103);
    arb_ready_out = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t3_hold_serial", arb_serial_out, 12'h103);
      chk("t3_hold_valid", arb_valid_out, 1);
      chk("t3_hold_last", arb_last_out, 0);
      step();
    end
    arb_ready_out = 1'b1;
    chk("t3_e2_release", arb_serial_out, 12'h103);
    step();
    chk("t3_e3", arb_serial_out, 12'h104);
    chk("t3_e3_last", arb_last_out, 0);
    step();
    chk("t3_e4", arb_serial_out, 12'h105);
    chk("t3_e4_last", arb_last_out, 1);
    step();
    chk("t3_idle_valid", arb_valid_out, 0);

    // Reset after element 2 of requester 1; requester 0 must win first afterwards
    arb_valid_in = 4'b0010;
    #1;
    chk("t4_grant", arb_ready_in, 4'b0010);
    step();
    arb_valid_in = 4'b0000;
    chk("t4_e0", arb_serial_out, 12'h101);
    step();
    chk("t4_e1", arb_serial_out, 12'h102);
    step();
    rst = 1'b0;
    arb_valid_in = 4'b1111;
    #1;
    chk("t4_ready_in_in_rst", arb_ready_in, 0);
    step();
    chk("t4_rst_valid", arb_valid_out, 0);
    chk("t4_rst_ready_in", arb_ready_in, 0);
    chk("t4_rst_serial", arb_serial_out, 0);
    chk("t4_rst_id", arb_id_out, 0);
    rst = 1'b1;
    #1;
    chk("t4_grant_after_rst", arb_ready_in, 4'b0001);
    step();
    arb_valid_in = 4'b0000;
    chk("t4_id_after_rst", arb_id_out, 0);
    chk("t4_serial_after_rst", arb_serial_out, 12'h001);
    for (int e = 0; e < 5; e++) step();
    chk("t4_idle_valid", arb_valid_out, 0);

    // Requester 3 drops and requester 0 raises valid mid-vector
    arb_valid_in = 4'b1000;
    #1;
    chk("t5_grant", arb_ready_in, 4'b1000);
    step();
    arb_valid_in = 4'b0001;
    for (int e = 0; e < 5; e++) begin
      chk("t5_id", arb_id_out, 3);
      chk("t5_serial", arb_serial_out, exp_data(3, e));
      chk("t5_last", arb_last_out, (e == 4) ? 1 : 0);
      chk("t5_ready_in_send", arb_ready_in, 0);
      step();
    end
    chk("t5_idle_valid", arb_valid_out, 0);
    chk("t5_grant0", arb_ready_in, 4'b0001);
    step();
    chk("t5_id0", arb_id_out, 0);
    chk("t5_serial0", arb_serial_out, 12'h001);
    chk("t5_valid0", arb_valid_out, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
